vx_tex_mem_responder: RTL and testbench

Memory-side responder for the texture unit's cache bus: it accepts word requests on `NUM_REQS` independent channels and serves them from an internal word-addressed store. Reads return data with the request tag after a fixed `LATENCY`; writes update the store and return no response. It sits in place of the texture cache behind the texture memory scheduler, for unit-level simulation and for small on-chip texture stores, and implements the responder end of that per-channel valid/ready request/response bus.

---
 rtl/vx_tex_mem_responder_if.sv | 37 +++
 rtl/vx_tex_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_vx_tex_mem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_tex_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_tex_mem_responder_if
// Purpose  : Per-channel valid/ready request/response bus between the texture
//            memory scheduler (master) and its memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface vx_tex_mem_responder_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH  = 8
);
  logic [NUM_REQS-1:0]                 mem_req_valid;
  logic [NUM_REQS-1:0]                 mem_req_rw;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] mem_req_addr;
  logic [NUM_REQS-1:0][3:0]            mem_req_byteen;
  logic [NUM_REQS-1:0][31:0]           mem_req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  mem_req_tag;
  logic [NUM_REQS-1:0]                 mem_req_ready;
  logic [NUM_REQS-1:0]                 mem_rsp_valid;
  logic [NUM_REQS-1:0][31:0]           mem_rsp_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  mem_rsp_tag;
  logic [NUM_REQS-1:0]                 mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface
`default_nettype wire

// File: rtl/vx_tex_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vx_tex_mem_responder
// Purpose  : Multi-channel word store answering texture cache-bus requests;
//            reads return data+tag after LATENCY cycles, writes are silent.
// Revision : 1.0 - initial release
// ============================================================================
module vx_tex_mem_responder #(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_REQS    = 4,
  parameter int    ADDR_WIDTH  = 8,
  parameter int    TAG_WIDTH   = 8,
  parameter int    LATENCY     = 2,
  parameter int    RSP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_tex_mem_responder_if.slave mem_if
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [31:0]         store_q [WORDS];
  logic [NUM_REQS-1:0] wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ascending channel order with non-blocking updates: the highest channel
  // writing a byte in a cycle is the one that lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (wr_en[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_if.mem_req_byteen[i][b]) begin
            store_q[mem_if.mem_req_addr[i]][8*b +: 8] <= mem_if.mem_req_data[i][8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_chan
    logic                 rd_fire;
    logic                 rsp_fire;
    logic [31:0]          rd_word;
    logic                 push;
    logic [31:0]          push_data;
    logic [TAG_WIDTH-1:0] push_tag;
    logic [CNT_W-1:0]     outst_q, outst_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [31:0]          fifo_data_q [RSP_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_DEPTH];

    assign mem_if.mem_req_ready[i] = (outst_q < CNT_W'(RSP_DEPTH));
    assign rd_fire  = mem_if.mem_req_valid[i] & mem_if.mem_req_ready[i] & ~mem_if.mem_req_rw[i];
    assign wr_en[i] = mem_if.mem_req_valid[i] & mem_if.mem_req_ready[i] &  mem_if.mem_req_rw[i];
    assign rsp_fire = mem_if.mem_rsp_valid[i] & mem_if.mem_rsp_ready[i];
    // Sampled before this cycle's writes take effect: read-before-write.
    assign rd_word  = store_q[mem_if.mem_req_addr[i]];

    // The accept cycle itself counts as the first latency stage.
    if (LATENCY == 1) begin : g_lat1
      assign push      = rd_fire;
      assign push_data = rd_word;
      assign push_tag  = mem_if.mem_req_tag[i];
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic [STAGES-1:0]    vld_q;
      logic [31:0]          data_q [STAGES];
      logic [TAG_WIDTH-1:0] tag_q  [STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= rd_fire;
          for (int k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_q[0] <= rd_word;
        tag_q[0]  <= mem_if.mem_req_tag[i];
        for (int k = 1; k < STAGES; k++) begin
          data_q[k] <= data_q[k-1];
          tag_q[k]  <= tag_q[k-1];
        end
      end

      assign push      = vld_q[STAGES-1];
      assign push_data = data_q[STAGES-1];
      assign push_tag  = tag_q[STAGES-1];
    end

    always_comb begin
      outst_d = outst_q;
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      case ({rd_fire, rsp_fire})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: outst_d = outst_q;
      endcase
      case ({push, rsp_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push)     wptr_d = ptr_inc(wptr_q);
      if (rsp_fire) rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        outst_q <= '0;
        count_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
      end else begin
        outst_q <= outst_d;
        count_q <= count_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        fifo_data_q[wptr_q] <= push_data;
        fifo_tag_q[wptr_q]  <= push_tag;
      end
    end

    assign mem_if.mem_rsp_valid[i] = (count_q != '0);
    assign mem_if.mem_rsp_data[i]  = fifo_data_q[rptr_q];
    assign mem_if.mem_rsp_tag[i]   = fifo_tag_q[rptr_q];
  end

`ifdef DBG_TRACE_TEX
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (mem_if.mem_req_valid[i] && mem_if.mem_req_ready[i])
          $display("%s: req ch=%0d rw=%0b addr=0x%0h byteen=0x%0h data=0x%0h tag=0x%0h",
                   INSTANCE_ID, i, mem_if.mem_req_rw[i], mem_if.mem_req_addr[i],
                   mem_if.mem_req_byteen[i], mem_if.mem_req_data[i], mem_if.mem_req_tag[i]);
        if (mem_if.mem_rsp_valid[i] && mem_if.mem_rsp_ready[i])
          $display("%s: rsp ch=%0d data=0x%0h tag=0x%0h",
                   INSTANCE_ID, i, mem_if.mem_rsp_data[i], mem_if.mem_rsp_tag[i]);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_tex_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_tex_mem_responder
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_tex_mem_responder;

  localparam int NR    = 4;
  localparam int AW    = 8;
  localparam int TW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    int            due;
  } rsp_t;

  typedef struct {
    bit            rw;
    int            ch;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic [31:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_tex_mem_responder_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  vx_tex_mem_responder #(
    .INSTANCE_ID ("tex_mem"),
    .NUM_REQS    (NR),
    .ADDR_WIDTH  (AW),
    .TAG_WIDTH   (TW),
    .LATENCY     (LAT),
    .RSP_DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (bus.slave)
  );

  // Reference model: word array, per-channel expected response queues and
  // outstanding credit counts.
  logic [31:0] mem_m [1 << AW];
  rsp_t        exp_q [NR][$];
  int          outst [NR];
  int          cyc;
  int          n_vec;
  int          n_err;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d cycle %0d: got 0x%0h expected 0x%0h", nm, ch, cyc, act, exp);
    end
  endtask

  task automatic clear_req();
    bus.mem_req_valid = '0;
    bus.mem_req_rw    = '0;
  endtask

  task automatic set_req(input int ch, input bit rw, input logic [AW-1:0] addr,
                         input logic [3:0] be, input logic [31:0] data, input logic [TW-1:0] tag);
    bus.mem_req_valid[ch]  = 1'b1;
    bus.mem_req_rw[ch]     = rw;
    bus.mem_req_addr[ch]   = addr;
    bus.mem_req_byteen[ch] = be;
    bus.mem_req_data[ch]   = data;
    bus.mem_req_tag[ch]    = tag;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NR; c++) begin
      exp_q[c].delete();
      outst[c] = 0;
    end
  endtask

  // Compare every channel's outputs for the current cycle against the model,
  // then cross one clock edge and apply this cycle's handshakes to the model.
  task automatic cycle();
    logic [NR-1:0] rf, wf, pf;
    rsp_t          e;
    for (int c = 0; c < NR; c++) begin
      bit er = (outst[c] < DEPTH);
      bit ev = (exp_q[c].size() > 0) && (exp_q[c][0].due <= cyc);
      chk("req_ready", c, {31'b0, bus.mem_req_ready[c]}, {31'b0, er});
      chk("rsp_valid", c, {31'b0, bus.mem_rsp_valid[c]}, {31'b0, ev});
      if (ev) begin
        chk("rsp_data", c, bus.mem_rsp_data[c], exp_q[c][0].data);
        chk("rsp_tag",  c, {24'b0, bus.mem_rsp_tag[c]}, {24'b0, exp_q[c][0].tag});
      end
      rf[c] = bus.mem_req_valid[c] && er && !bus.mem_req_rw[c];
      wf[c] = bus.mem_req_valid[c] && er &&  bus.mem_req_rw[c];
      pf[c] = ev && bus.mem_rsp_ready[c];
    end
    @(posedge clk);
    for (int c = 0; c < NR; c++) begin
      if (pf[c]) begin
        void'(exp_q[c].pop_front());
        outst[c]--;
      end
      if (rf[c]) begin
        e.data = mem_m[bus.mem_req_addr[c]];
        e.tag  = bus.mem_req_tag[c];
        e.due  = cyc + LAT;
        exp_q[c].push_back(e);
        outst[c]++;
      end
    end
    for (int c = 0; c < NR; c++) begin
      if (wf[c]) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_req_byteen[c][b])
            mem_m[bus.mem_req_addr[c]][8*b +: 8] = bus.mem_req_data[c][8*b +: 8];
        end
      end
    end
    cyc++;
    #1;
  endtask

  // Called in the cycle after a read was issued; waits (bounded) for its response.
  task automatic wait_rsp(input int ch, output logic [31:0] d, output logic [TW-1:0] t, output int lat);
    lat = 1;
    while (!bus.mem_rsp_valid[ch] && lat < 16) begin
      cycle();
      lat++;
    end
    d = bus.mem_rsp_data[ch];
    t = bus.mem_rsp_tag[ch];
    if (!bus.mem_rsp_valid[ch]) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout ch%0d cycle %0d: got no response expected one within 16 cycles", ch, cyc);
    end
  endtask

  vec_t tbl [10];

  initial begin
    logic [31:0]   d;
    logic [TW-1:0] t;
    int            lat;
    int            k;
    int            first_pop;
    int            acc5;
    int            cnt;
    logic [TW-1:0] got_tags [$];

    tbl[0] = '{1, 0, 8'h10, 4'hF, 32'hDEADBEEF, 8'h00, 32'h0};
    tbl[1] = '{0, 0, 8'h10, 4'h0, 32'h0,        8'h05, 32'hDEADBEEF};
    tbl[2] = '{1, 1, 8'h20, 4'hF, 32'h11223344, 8'h00, 32'h0};
    tbl[3] = '{1, 1, 8'h20, 4'h5, 32'hAABBCCDD, 8'h00, 32'h0};
    tbl[4] = '{0, 1, 8'h20, 4'h0, 32'h0,        8'h21, 32'h11BB33DD};
    tbl[5] = '{1, 3, 8'h40, 4'hF, 32'h00000000, 8'h00, 32'h0};
    tbl[6] = '{1, 3, 8'h40, 4'hA, 32'h12345678, 8'h00, 32'h0};
    tbl[7] = '{0, 3, 8'h40, 4'h0, 32'h0,        8'h43, 32'h12005600};
    tbl[8] = '{1, 2, 8'h20, 4'h8, 32'hCAFEF00D, 8'h00, 32'h0};
    tbl[9] = '{0, 2, 8'h20, 4'h0, 32'h0,        8'h99, 32'hCABB33DD};

    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();
    clear_req();
    bus.mem_req_addr   = '0;
    bus.mem_req_byteen = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_tag    = '0;
    bus.mem_rsp_ready  = '1;

    // Reset state
    #1;
    chk("reset_ready", 0, {28'b0, bus.mem_req_ready}, 32'hF);
    chk("reset_valid", 0, {28'b0, bus.mem_rsp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Preload words 0..31 so every later read targets defined contents
    for (int a = 0; a < 32; a += NR) begin
      for (int c = 0; c < NR; c++) set_req(c, 1, AW'(a + c), 4'hF, $urandom, 8'h00);
      cycle();
    end
    clear_req();
    cycle();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      clear_req();
      set_req(tbl[i].ch, tbl[i].rw, tbl[i].addr, tbl[i].be, tbl[i].data, tbl[i].tag);
      cycle();
      clear_req();
      if (!tbl[i].rw) begin
        wait_rsp(tbl[i].ch, d, t, lat);
        chk("tbl_data",    tbl[i].ch, d, tbl[i].exp);
        chk("tbl_tag",     tbl[i].ch, {24'b0, t}, {24'b0, tbl[i].tag});
        chk("tbl_latency", tbl[i].ch, lat, LAT);
        cycle();
      end
    end

    // Backpressure fill on ch1
    bus.mem_rsp_ready = '0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bit r;
      set_req(1, 0, AW'(k), 4'h0, 32'h0, TW'(8'h60 + k));
      r = bus.mem_req_ready[1];
      cycle();
      if (r) k++;
    end
    chk("bp_accepted", 1, k, 4);
    chk("bp_ready_low", 1, {31'b0, bus.mem_req_ready[1]}, 32'h0);
    bus.mem_rsp_ready[1] = 1'b1;
    first_pop = -1;
    acc5 = -1;
    for (int c = 0; c < 20; c++) begin
      bit r, p;
      if (k < 6) set_req(1, 0, AW'(k), 4'h0, 32'h0, TW'(8'h60 + k));
      else clear_req();
      r = bus.mem_req_ready[1] && (k < 6);
      p = bus.mem_rsp_valid[1];
      if (p) got_tags.push_back(bus.mem_rsp_tag[1]);
      cycle();
      if (p && first_pop < 0) first_pop = c;
      if (r) begin
        if (k == 4) acc5 = c;
        k++;
      end
    end
    chk("bp_5th_after_pop", 1, acc5 - first_pop, 1);
    chk("bp_rsp_count", 1, got_tags.size(), 6);
    for (int j = 0; j < 6 && j < got_tags.size(); j++)
      chk("bp_tag_order", 1, {24'b0, got_tags[j]}, 32'h60 + j);
    clear_req();
    bus.mem_rsp_ready = '1;
    repeat (4) cycle();

    // Same-cycle collision: read-before-write, highest channel wins
    set_req(0, 1, 8'h07, 4'hF, 32'h9, 8'h00);
    cycle();
    clear_req();
    set_req(0, 1, 8'h07, 4'hF, 32'h1, 8'h00);
    set_req(3, 1, 8'h07, 4'hF, 32'h3, 8'h00);
    set_req(2, 0, 8'h07, 4'h0, 32'h0, 8'h72);
    cycle();
    clear_req();
    wait_rsp(2, d, t, lat);
    chk("coll_old_value", 2, d, 32'h9);
    cycle();
    set_req(1, 0, 8'h07, 4'h0, 32'h0, 8'h17);
    cycle();
    clear_req();
    wait_rsp(1, d, t, lat);
    chk("coll_winner", 1, d, 32'h3);
    cycle();

    // Simultaneous read fire and response fire with 2 outstanding
    bus.mem_rsp_ready[0] = 1'b0;
    set_req(0, 0, 8'h02, 4'h0, 32'h0, 8'hB0);
    cycle();
    set_req(0, 0, 8'h03, 4'h0, 32'h0, 8'hB1);
    cycle();
    clear_req();
    wait_rsp(0, d, t, lat);
    set_req(0, 0, 8'h04, 4'h0, 32'h0, 8'hB2);
    bus.mem_rsp_ready[0] = 1'b1;
    cycle();
    chk("incdec_ready", 0, {31'b0, bus.mem_req_ready[0]}, 32'h1);
    bus.mem_rsp_ready[0] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      bit r;
      set_req(0, 0, AW'(8 + c), 4'h0, 32'h0, TW'(8'hC0 + c));
      r = bus.mem_req_ready[0];
      cycle();
      if (!r) break;
      cnt++;
    end
    chk("incdec_credits", 0, cnt, 2);
    clear_req();
    bus.mem_rsp_ready = '1;
    repeat (8) cycle();

    // Reset mid-flight
    bus.mem_rsp_ready = '0;
    for (int j = 0; j < 3; j++) begin
      set_req(0, 0, AW'(j), 4'h0, 32'h0, TW'(8'hA0 + j));
      cycle();
    end
    clear_req();
    cycle();
    chk("pre_reset_valid", 0, {31'b0, bus.mem_rsp_valid[0]}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 0, {28'b0, bus.mem_rsp_valid}, 32'h0);
    chk("midrst_ready", 0, {28'b0, bus.mem_req_ready}, 32'hF);
    model_reset();
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    bus.mem_rsp_ready = '1;
    repeat (8) cycle();
    chk("postrst_ready", 0, {28'b0, bus.mem_req_ready}, 32'hF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NR; c++) begin
        bus.mem_req_valid[c]  = $urandom_range(0, 1) == 1;
        bus.mem_req_rw[c]     = $urandom_range(0, 2) == 0;
        bus.mem_req_addr[c]   = AW'($urandom_range(0, 15));
        bus.mem_req_byteen[c] = 4'($urandom);
        bus.mem_req_data[c]   = $urandom;
        bus.mem_req_tag[c]    = TW'($urandom);
        bus.mem_rsp_ready[c]  = $urandom_range(0, 3) != 0;
      end
      cycle();
    end
    clear_req();
    bus.mem_rsp_ready = '1;
    repeat (12) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
